// File: rtl/sha256_msg_sched_if.sv
// SHA-256 message scheduler bus: message-word write port, step requests and Wt return.
// The controller side drives start/load/stn/round_t; the scheduler returns Wt and status.
// No flow control beyond the stn request pulse and the wt_valid response pulse.
interface sha256_msg_sched_if;
  logic        start;
  logic [31:0] msg_word_in;
  logic [3:0]  msg_word_addr;
  logic        msg_we;
  logic        stn;
  logic [5:0]  round_t;
  logic [31:0] wt_out;
  logic        wt_valid;
  logic        sched_ready;
  logic        sched_done;
  logic        round_err;

  modport master (
    output start, msg_word_in, msg_word_addr, msg_we, stn, round_t,
    input  wt_out, wt_valid, sched_ready, sched_done, round_err
  );

  modport slave (
    input  start, msg_word_in, msg_word_addr, msg_we, stn, round_t,
    output wt_out, wt_valid, sched_ready, sched_done, round_err
  );
endinterface

// File: rtl/sha256_msg_sched.sv
// SHA-256 message scheduler: 16-word rolling W window, one Wt per stn for t = 0..63.
// Latency: stn in cycle N -> wt_valid with Wt in cycle N+1; full rate back-to-back stn.
// No backpressure; SCHED_ROUND_CHECK_EN adds a sticky round_t vs t_cnt mismatch flag.
module sha256_msg_sched #(
  parameter int ROUNDS = 64,
  parameter int WORD_W = 32
) (
  input logic             clk,
  input logic             reset_n,
  sha256_msg_sched_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t            state;
  logic [WORD_W-1:0] w [16];
  logic [15:0]       load_mask;
  logic [15:0]       mask_next;
  logic [5:0]        t_cnt;
  logic [3:0]        slot;
  logic [WORD_W-1:0] wt_calc;
  logic [WORD_W-1:0] wt_q;
  logic              wt_valid_q;
  logic              ready_q;
  logic              done_q;

  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic logic [WORD_W-1:0] sig0(input logic [WORD_W-1:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [WORD_W-1:0] sig1(input logic [WORD_W-1:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Next Wt from the circular window; slot arithmetic wraps mod 16 in 4 bits,
  // and slot t mod 16 currently holds W[t-16].
  always_comb begin
    slot      = t_cnt[3:0];
    mask_next = load_mask | (bus.msg_we ? (16'd1 << bus.msg_word_addr) : 16'd0);
    wt_calc   = w[slot];
    if (t_cnt >= 6'd16) begin
      wt_calc = sig1(w[slot - 4'd2]) + w[slot - 4'd7] + sig0(w[slot - 4'd15]) + w[slot];
    end
  end

  // Control FSM with window storage and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      for (int i = 0; i < 16; i++) w[i] <= '0;
      load_mask  <= '0;
      t_cnt      <= '0;
      wt_q       <= '0;
      wt_valid_q <= 1'b0;
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      wt_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state     <= LOAD;
            load_mask <= '0;
            t_cnt     <= '0;
          end
        end
        LOAD: begin
          if (!bus.start) begin
            state <= IDLE;
          end else begin
            if (bus.msg_we) begin
              w[bus.msg_word_addr] <= bus.msg_word_in;
            end
            load_mask <= mask_next;
            // Enter RUN on the edge where the last missing slot is written.
            if (mask_next == 16'hFFFF) begin
              state   <= RUN;
              ready_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (!bus.start) begin
            state   <= IDLE;
            ready_q <= 1'b0;
          end else if (bus.stn) begin
            wt_q       <= wt_calc;
            wt_valid_q <= 1'b1;
            t_cnt      <= t_cnt + 6'd1;
            if (t_cnt >= 6'd16) begin
              w[slot] <= wt_calc;
            end
            if (t_cnt == 6'(ROUNDS - 1)) begin
              state   <= DONE;
              ready_q <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        DONE: begin
          if (!bus.start) begin
            state  <= IDLE;
            done_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.wt_out      = wt_q;
  assign bus.wt_valid    = wt_valid_q;
  assign bus.sched_ready = ready_q;
  assign bus.sched_done  = done_q;

`ifdef SCHED_ROUND_CHECK_EN
  logic round_err_q;

  // Sticky round-index mismatch flag, cleared when a new block starts loading.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      round_err_q <= 1'b0;
    end else if (state == IDLE && bus.start) begin
      round_err_q <= 1'b0;
    end else if (state == RUN && bus.start && bus.stn && (bus.round_t != t_cnt)) begin
      round_err_q <= 1'b1;
    end
  end

  assign bus.round_err = round_err_q;
`else
  assign bus.round_err = 1'b0;
`endif

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Directed bench for sha256_msg_sched: "abc" block, out-of-order load, reset and abort.
// Inputs are driven and outputs sampled 1 ns after each rising clock edge.
// Build with SCHED_ROUND_CHECK_EN defined to exercise the round mismatch flag.
module tb_sha256_msg_sched;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  logic [31:0] msg [16];
  logic [31:0] exp_w [64];

  sha256_msg_sched_if bus ();

  sha256_msg_sched #(.ROUNDS(64), .WORD_W(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=0x%08h want=0x%08h", tag, got, want);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Reference expansion over a flat 64-entry array.
  task automatic build_model();
    for (int t = 0; t < 64; t++) begin
      if (t < 16) exp_w[t] = msg[t];
      else exp_w[t] = (rr(exp_w[t-2], 17) ^ rr(exp_w[t-2], 19) ^ (exp_w[t-2] >> 10))
                    + exp_w[t-7]
                    + (rr(exp_w[t-15], 7) ^ rr(exp_w[t-15], 18) ^ (exp_w[t-15] >> 3))
                    + exp_w[t-16];
    end
  endtask

  task automatic load_in_order();
    for (int i = 0; i < 16; i++) begin
      bus.msg_we        = 1'b1;
      bus.msg_word_addr = 4'(i);
      bus.msg_word_in   = msg[i];
      cyc();
      if (i == 14) check("ready_before_last", 32'(bus.sched_ready), 32'd0);
    end
    bus.msg_we = 1'b0;
  endtask

  initial begin
    int order [17];
    checks = 0;
    errors = 0;
    reset_n           = 1'b0;
    bus.start         = 1'b0;
    bus.msg_word_in   = '0;
    bus.msg_word_addr = '0;
    bus.msg_we        = 1'b0;
    bus.stn           = 1'b0;
    bus.round_t       = '0;

    // Reset state
    #12;
    check("rst_wt_out", bus.wt_out, 32'd0);
    check("rst_wt_valid", 32'(bus.wt_valid), 32'd0);
    check("rst_ready", 32'(bus.sched_ready), 32'd0);
    check("rst_done", 32'(bus.sched_done), 32'd0);
    check("rst_round_err", 32'(bus.round_err), 32'd0);
    reset_n = 1'b1;
    cyc();

    // "abc" block
    for (int i = 0; i < 16; i++) msg[i] = 32'h0;
    msg[0]  = 32'h61626380;
    msg[15] = 32'h00000018;
    build_model();
    bus.start = 1'b1;
    cyc();
    load_in_order();
    check("abc_ready_after_16th", 32'(bus.sched_ready), 32'd1);
    for (int t = 0; t < 64; t++) begin
      bus.stn     = 1'b1;
      bus.round_t = 6'(t);
      cyc();
      check("abc_valid", 32'(bus.wt_valid), 32'd1);
      check($sformatf("abc_w%0d", t), bus.wt_out, exp_w[t]);
      if (t == 0)  check("abc_w0_hand", bus.wt_out, 32'h61626380);
      if (t == 15) check("abc_w15_hand", bus.wt_out, 32'h00000018);
      if (t == 16) check("abc_w16_hand", bus.wt_out, 32'h61626380);
      if (t == 17) check("abc_w17_hand", bus.wt_out, 32'h000F0000);
      if (t == 18) check("abc_w18_hand", bus.wt_out, 32'h7DA86405);
    end
    check("abc_done_after_last", 32'(bus.sched_done), 32'd1);
    cyc();
    check("done_stn_no_valid", 32'(bus.wt_valid), 32'd0);
    check("done_wt_hold", bus.wt_out, exp_w[63]);
    check("done_ready_low", 32'(bus.sched_ready), 32'd0);
    bus.stn = 1'b0;
    bus.start = 1'b0;
    cyc();
    check("done_to_idle", 32'(bus.sched_done), 32'd0);
    cyc();

    // Out-of-order load with duplicate slot 5, stn during LOAD
    order = '{5, 3, 10, 0, 12, 7, 1, 14, 5, 9, 2, 15, 4, 11, 6, 13, 8};
    for (int i = 0; i < 16; i++) msg[i] = 32'hA0000000 | 32'(i);
    msg[5] = 32'h00002222;
    build_model();
    bus.start = 1'b1;
    cyc();
    for (int i = 0; i < 17; i++) begin
      bus.msg_we        = 1'b1;
      bus.msg_word_addr = 4'(order[i]);
      bus.msg_word_in   = (i == 0) ? 32'h00001111 : msg[order[i]];
      bus.stn           = (i == 3);
      cyc();
      if (i == 3) check("load_stn_no_valid", 32'(bus.wt_valid), 32'd0);
      if (i == 8) check("dup_not_ready", 32'(bus.sched_ready), 32'd0);
      if (i == 15) check("ooo_not_ready_15", 32'(bus.sched_ready), 32'd0);
    end
    bus.msg_we = 1'b0;
    check("ooo_ready", 32'(bus.sched_ready), 32'd1);
    for (int t = 0; t < 20; t++) begin
      bus.stn     = 1'b1;
      bus.round_t = 6'(t);
      cyc();
      check($sformatf("ooo_w%0d", t), bus.wt_out, exp_w[t]);
      if (t == 5) check("ooo_w5_dup", bus.wt_out, 32'h00002222);
    end
    bus.stn = 1'b0;

    // Asynchronous reset mid-RUN
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("arst_wt_out", bus.wt_out, 32'd0);
    check("arst_ready", 32'(bus.sched_ready), 32'd0);
    check("arst_valid", 32'(bus.wt_valid), 32'd0);
    check("arst_done", 32'(bus.sched_done), 32'd0);
    bus.start = 1'b0;
    cyc();
    reset_n = 1'b1;
    cyc();

    // Fresh block after reset, round check, abort at t=30
    for (int i = 0; i < 16; i++) msg[i] = 32'h01000000 * 32'(i + 1) + 32'h5A5A;
    build_model();
    bus.start = 1'b1;
    cyc();
    load_in_order();
    check("c_ready", 32'(bus.sched_ready), 32'd1);
    for (int t = 0; t < 30; t++) begin
      bus.stn = 1'b1;
`ifdef SCHED_ROUND_CHECK_EN
      bus.round_t = (t == 6) ? 6'd7 : 6'(t);
`else
      bus.round_t = 6'(t);
`endif
      cyc();
      check($sformatf("c_w%0d", t), bus.wt_out, exp_w[t]);
      if (t == 5) check("c_err_before", 32'(bus.round_err), 32'd0);
`ifdef SCHED_ROUND_CHECK_EN
      if (t == 6)  check("c_err_set", 32'(bus.round_err), 32'd1);
      if (t == 29) check("c_err_sticky", 32'(bus.round_err), 32'd1);
`else
      if (t == 6)  check("c_err_tied", 32'(bus.round_err), 32'd0);
`endif
    end
    check("c_w0_is_msg0", exp_w[0], 32'h01005A5A);
    bus.stn = 1'b1;
    bus.start = 1'b0;
    cyc();
    check("abort_no_valid", 32'(bus.wt_valid), 32'd0);
    check("abort_ready_low", 32'(bus.sched_ready), 32'd0);
    check("abort_wt_hold", bus.wt_out, exp_w[29]);
    cyc();
    check("abort_idle_valid", 32'(bus.wt_valid), 32'd0);
    check("abort_idle_ready", 32'(bus.sched_ready), 32'd0);
    bus.stn = 1'b0;
    bus.start = 1'b1;
    cyc();
    check("restart_err_clear", 32'(bus.round_err), 32'd0);
    check("restart_not_ready", 32'(bus.sched_ready), 32'd0);
    bus.start = 1'b0;
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sha256_msg_sched.md
Name: sha256_msg_sched

Overview:
- SHA-256 message scheduler: holds the 16-word rolling W window and produces one Wt per compression-round request, for t = 0..63.
- Sits directly downstream of the SHA-256 controller. Receives the 16 message words through a write port, then returns Wt to the controller each time the compression core signals step-to-next (stn).
- One 512-bit block per start; multi-block chaining is handled upstream.

Parameters:
- ROUNDS, 64, number of Wt words produced per block (fixed at 64 for SHA-256; other values unsupported).
- WORD_W, 32, word width in bits (fixed at 32).

Ports:
- clk  in  1  system clock; already decided.
- reset_n  in  1  reset, asynchronous, active-low; already decided.
- start  in  1  level; high enables a block, low aborts or releases it.
- msg_word_in  in  32  message word to load.
- msg_word_addr  in  4  window slot 0..15 for msg_word_in.
- msg_we  in  1  write strobe for the message word.
- stn  in  1  single-cycle synchronous pulse requesting the next Wt.
- round_t  in  6  controller's round index; used only by the optional check.
- wt_out  out  32  scheduled word Wt, registered.
- wt_valid  out  1  one-cycle pulse; wt_out is valid.
- sched_ready  out  1  high in RUN (all 16 words loaded).
- sched_done  out  1  high in DONE (W63 delivered).
- round_err  out  1  sticky mismatch flag; tied 0 unless SCHED_ROUND_CHECK_EN is defined.

Behaviour:
- Reset (async): state=IDLE; W[0..15]=0; t_cnt=0; load mask=0; wt_out=0; wt_valid, sched_ready, sched_done and round_err all 0.
- States: IDLE, LOAD, RUN, DONE.
  - IDLE -> LOAD when start=1. Clears the 16-bit load mask and t_cnt.
  - LOAD: msg_we=1 writes W[msg_word_addr] and sets mask bit. Rewriting an already-written slot overwrites the word; the mask is unchanged. -> RUN on the cycle after mask reaches 0xFFFF.
  - RUN: sched_ready=1. On stn, compute Wt for t=t_cnt, register it into wt_out, pulse wt_valid on the next cycle, and increment t_cnt. -> DONE on the cycle after the stn with t_cnt=63.
  - DONE: sched_done=1; wt_out holds W63. -> IDLE when start=0.
- start=0 in LOAD or RUN: abort to IDLE next cycle. wt_valid is not generated for an stn arriving in the same cycle. W contents are retained but invalid.
- Wt computation (all additions mod 2^32, slot index = (t-k) mod 16):
  - t<16: Wt=W[t].
  - t>=16: Wt = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16]. The result is written into slot t mod 16, overwriting W[t-16], in the same clock edge that loads wt_out.
  - s0(x) = ROTR7 ^ ROTR18 ^ SHR3.
  - s1(x) = ROTR17 ^ ROTR19 ^ SHR10.
- Latency: stn at cycle N -> wt_valid=1 with wt_out=Wt at cycle N+1. Back-to-back stn every cycle is supported at full rate.
- stn in IDLE, LOAD or DONE: ignored, with no output change. msg_we outside LOAD: ignored.
- stn and start falling in the same cycle: abort wins.
- wt_valid is 0 in every cycle without a serviced stn.

Optional Feature:
- Macro SCHED_ROUND_CHECK_EN.
- Defined:
  - On each serviced stn, compare round_t with t_cnt.
  - On mismatch, set round_err, which stays set until the next IDLE->LOAD transition or reset.
  - Wt is still produced from t_cnt.
- Undefined: round_err is constant 0, round_t is unused, and no comparator is synthesized.

Test Plan:
- Reset mid-RUN (after 20 stn) -> all outputs 0 immediately. A fresh start plus 16 loads -> first stn returns W0 again.
- "abc" block, stimulus:
  - start=1; load W0=0x61626380, W1..W14=0, W15=0x00000018 in order.
  - sched_ready=1 exactly one cycle after the 16th write.
  - Issue 64 stn, one per cycle.
- "abc" block, required response:
  - wt_valid pulses 64 times: Wt0=0x61626380, Wt15=0x00000018, Wt16=0x61626380, Wt17=0x000F0000, Wt18=0x7DA86405.
  - All 64 words match the software model.
  - sched_done=1 after the last pulse.
- Loads out of order with a duplicate addr 5 (0x1111 then 0x2222) -> RUN is entered only after all 16 slots are written. Wt5=0x00002222.
- stn during LOAD and during DONE -> no wt_valid, t_cnt unchanged. Deasserting start in DONE -> IDLE.
- start dropped at t=30 together with stn -> no wt_valid on the next cycle, and state returns to IDLE.
- With SCHED_ROUND_CHECK_EN defined, round_t=7 while t_cnt=6 -> round_err=1, and it persists until the next start; wt_out=W6 is still correct.
